ufifo_ext: RTL and testbench

Parametrised synchronous FIFO for the UART data paths, replacing the fixed 8-bit, sixteen-entry buffer. It sits between the Wishbone register interface and the rx/tx serialisers, and adds the following over the previous generation:
- arbitrary data width;
- true full-depth capacity;
- first-word fall-through output;
- a programmable fill/free threshold interrupt;
- flush;
- separate sticky overflow/underflow flags with software clear.

The status word keeps the existing 16-bit layout, so register decode is unchanged.

---
 rtl/ufifo_ext.sv | 59 +++++
 tb/tb_ufifo_ext.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ufifo_ext.sv
// ufifo_ext: parametrised FWFT synchronous FIFO with threshold, flush and sticky error flags.
module ufifo_ext #(
  parameter int BW = 8,
  parameter int LGFLEN = 4,
  parameter int RXFIFO = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_empty_n,
  output logic              o_full,
  input  logic [LGFLEN:0]   i_thresh,
  output logic              o_thresh,
  output logic              o_half_full,
  output logic [LGFLEN:0]   o_fill,
  input  logic              i_clr_err,
  output logic              o_ovfl,
  output logic              o_unfl,
  output logic [15:0]       o_status
);
  localparam int FLEN = 1 << LGFLEN;
  localparam logic [LGFLEN:0] FLEN_W = (LGFLEN+1)'(FLEN);
  logic [BW-1:0] mem [FLEN];
  logic [LGFLEN:0] wptr, rptr, w_nx, r_nx, fill_nx, cnt_nx, cnt;
  logic wr_ok, rd_ok, ovfl_set, unfl_set;
  always_comb begin
    wr_ok = i_wr && (!o_full || i_rd) && !i_flush;
    rd_ok = i_rd && o_empty_n && !i_flush;
    ovfl_set = i_wr && o_full && !i_rd && !i_flush;
    unfl_set = i_rd && !o_empty_n && !i_flush;
    w_nx = (i_rst || i_flush) ? '0 : wptr + (LGFLEN+1)'(wr_ok);
    r_nx = (i_rst || i_flush) ? '0 : rptr + (LGFLEN+1)'(rd_ok);
    fill_nx = w_nx - r_nx;
    cnt_nx = (RXFIFO != 0) ? fill_nx : FLEN_W - fill_nx;
    cnt = (RXFIFO != 0) ? o_fill : FLEN_W - o_fill;
  end
  always_ff @(posedge i_clk) begin
    wptr <= w_nx;
    rptr <= r_nx;
    o_fill <= fill_nx;
    o_empty_n <= fill_nx != '0;
    o_full <= fill_nx == FLEN_W;
    o_half_full <= fill_nx >= (FLEN_W >> 1);
    o_thresh <= (i_thresh != '0) && (cnt_nx >= i_thresh);
    o_ovfl <= !i_rst && (ovfl_set || (o_ovfl && !i_clr_err));
    o_unfl <= !i_rst && (unfl_set || (o_unfl && !i_clr_err));
  end
  // Head register: a write landing exactly at the next read pointer bypasses the RAM.
  always_ff @(posedge i_clk) begin
    if (wr_ok && !i_rst)
      mem[wptr[LGFLEN-1:0]] <= i_data;
    o_data <= (wr_ok && wptr == r_nx) ? i_data : mem[r_nx[LGFLEN-1:0]];
  end
  assign o_status = {4'(LGFLEN), 12'({cnt, o_half_full, o_empty_n})};
endmodule

// File: tb/tb_ufifo_ext.sv
// tb_ufifo_ext: scoreboard bench driving an rx-mode and a tx-mode ufifo_ext in lockstep.
module tb_ufifo_ext;
  logic i_clk = 0, i_rst = 0, i_flush = 0, i_wr = 0, i_rd = 0, i_clr_err = 0;
  logic [7:0] i_data = 0;
  logic [4:0] i_thresh = 0;
  logic [7:0] o_data, t_data;
  logic o_empty_n, o_full, o_thresh, o_half_full, o_ovfl, o_unfl;
  logic t_empty_n, t_full, t_thresh, t_half_full, t_ovfl, t_unfl;
  logic [4:0] o_fill, t_fill;
  logic [15:0] o_status, t_status;
  logic [7:0] q[$];
  logic m_ovfl = 0, m_unfl = 0;
  int n_tests = 0, n_fail = 0;

  always #5 i_clk = ~i_clk;

  ufifo_ext #(.BW(8), .LGFLEN(4), .RXFIFO(1)) dut_rx (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_wr(i_wr), .i_data(i_data),
    .i_rd(i_rd), .o_data(o_data), .o_empty_n(o_empty_n), .o_full(o_full),
    .i_thresh(i_thresh), .o_thresh(o_thresh), .o_half_full(o_half_full), .o_fill(o_fill),
    .i_clr_err(i_clr_err), .o_ovfl(o_ovfl), .o_unfl(o_unfl), .o_status(o_status));

  ufifo_ext #(.BW(8), .LGFLEN(4), .RXFIFO(0)) dut_tx (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_wr(i_wr), .i_data(i_data),
    .i_rd(i_rd), .o_data(t_data), .o_empty_n(t_empty_n), .o_full(t_full),
    .i_thresh(i_thresh), .o_thresh(t_thresh), .o_half_full(t_half_full), .o_fill(t_fill),
    .i_clr_err(i_clr_err), .o_ovfl(t_ovfl), .o_unfl(t_unfl), .o_status(t_status));

  task automatic tick();
    bit full, ov, un;
    if (i_rd && !i_rst && !i_flush && q.size() != 0) begin
      n_tests++;
      if (o_data !== q[0] || t_data !== q[0]) begin
        n_fail++;
        $display("FAIL pop_data: rx %h tx %h expected %h", o_data, t_data, q[0]);
      end
    end
    @(posedge i_clk);
    if (i_rst) begin
      q.delete(); m_ovfl = 0; m_unfl = 0;
    end else if (i_flush) begin
      q.delete(); m_ovfl = m_ovfl && !i_clr_err; m_unfl = m_unfl && !i_clr_err;
    end else begin
      full = q.size() == 16;
      ov = i_wr && full && !i_rd;
      un = i_rd && q.size() == 0;
      if (i_rd && q.size() != 0) void'(q.pop_front());
      if (i_wr && (!full || i_rd)) q.push_back(i_data);
      m_ovfl = ov || (m_ovfl && !i_clr_err);
      m_unfl = un || (m_unfl && !i_clr_err);
    end
    #1;
    i_rst = 0; i_flush = 0; i_wr = 0; i_rd = 0; i_clr_err = 0;
  endtask

  task automatic wr(input logic [7:0] d);
    i_wr = 1; i_data = d; tick();
  endtask

  task automatic rd();
    i_rd = 1; tick();
  endtask

  task automatic test_reset();
    i_thresh = 4; i_rst = 1; tick();
    n_tests++;
    if ({o_fill, o_empty_n, o_full, o_half_full, o_ovfl, o_unfl, o_thresh} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_flags: fill %0d e %b f %b h %b ov %b un %b th %b expected all 0",
               o_fill, o_empty_n, o_full, o_half_full, o_ovfl, o_unfl, o_thresh);
    end
    n_tests++;
    if (t_thresh !== 1'b1) begin n_fail++; $display("FAIL reset_tx_thresh: got %b expected 1", t_thresh); end
    n_tests++;
    if (o_status !== 16'h4000 || t_status !== 16'h4040) begin
      n_fail++; $display("FAIL reset_status: rx %h tx %h expected 4000/4040", o_status, t_status);
    end
  endtask

  task automatic test_fill_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) wr(8'(r * 16 + i));
      n_tests++;
      if (o_full !== 1'b1 || o_fill !== 5'd16 || o_status[6:2] !== 5'd16) begin
        n_fail++; $display("FAIL full_%0d: full %b fill %0d st %0d expected 1/16/16", r, o_full, o_fill, o_status[6:2]);
      end
      wr(8'hAA);
      n_tests++;
      if (o_ovfl !== 1'b1 || o_fill !== 5'd16) begin
        n_fail++; $display("FAIL ovfl_%0d: ovfl %b fill %0d expected 1/16", r, o_ovfl, o_fill);
      end
      i_clr_err = 1; tick();
      n_tests++;
      if (o_ovfl !== 1'b0) begin n_fail++; $display("FAIL clr_ovfl_%0d: got %b expected 0", r, o_ovfl); end
      for (int i = 0; i < 16; i++) rd();
      n_tests++;
      if (o_empty_n !== 1'b0 || o_fill !== 5'd0 || o_unfl !== 1'b0) begin
        n_fail++; $display("FAIL drain_%0d: empty_n %b fill %0d unfl %b expected 0/0/0", r, o_empty_n, o_fill, o_unfl);
      end
    end
  endtask

  task automatic test_fwft();
    wr(8'h5C);
    n_tests++;
    if (o_empty_n !== 1'b1 || o_data !== 8'h5C) begin
      n_fail++; $display("FAIL fwft_latency: empty_n %b data %h expected 1/5c", o_empty_n, o_data);
    end
    rd();
    n_tests++;
    if (o_empty_n !== 1'b0 || o_unfl !== 1'b0) begin
      n_fail++; $display("FAIL fwft_pop: empty_n %b unfl %b expected 0/0", o_empty_n, o_unfl);
    end
  endtask

  task automatic test_simul();
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i));
    for (int i = 0; i < 8; i++) begin
      i_wr = 1; i_rd = 1; i_data = 8'(8'h80 + i); tick();
      n_tests++;
      if (o_full !== 1'b1 || o_ovfl !== 1'b0) begin
        n_fail++; $display("FAIL simul_full_%0d: full %b ovfl %b expected 1/0", i, o_full, o_ovfl);
      end
    end
    for (int i = 0; i < 16; i++) rd();
    i_wr = 1; i_rd = 1; i_data = 8'h77; tick();
    n_tests++;
    if (o_unfl !== m_unfl || o_unfl !== 1'b1 || o_fill !== 5'd1 || o_data !== 8'h77) begin
      n_fail++; $display("FAIL simul_empty: unfl %b fill %0d data %h expected 1/1/77", o_unfl, o_fill, o_data);
    end
    rd();
    i_clr_err = 1; tick();
  endtask

  task automatic test_thresh();
    i_thresh = 12;
    for (int i = 0; i < 12; i++) begin
      wr(8'(i));
      n_tests++;
      if (o_thresh !== (q.size() >= 12) || t_thresh !== ((16 - q.size()) >= 12)) begin
        n_fail++; $display("FAIL thr12_w%0d: rx %b tx %b fill %0d", i, o_thresh, t_thresh, q.size());
      end
    end
    rd();
    n_tests++;
    if (o_thresh !== 1'b0) begin n_fail++; $display("FAIL thr12_fall: got %b expected 0", o_thresh); end
    i_thresh = 4;
    while (q.size() < 16) begin
      wr(8'hC0);
      n_tests++;
      if (t_thresh !== (q.size() <= 12) || o_thresh !== (q.size() >= 4)) begin
        n_fail++; $display("FAIL thr4: rx %b tx %b fill %0d", o_thresh, t_thresh, q.size());
      end
    end
    i_thresh = 0;
    while (q.size() > 0) begin
      rd();
      n_tests++;
      if (o_thresh !== 1'b0 || t_thresh !== 1'b0) begin
        n_fail++; $display("FAIL thr0: rx %b tx %b expected 0/0 fill %0d", o_thresh, t_thresh, q.size());
      end
    end
  endtask

  task automatic test_flush_err();
    for (int i = 0; i < 16; i++) wr(8'(8'h20 + i));
    wr(8'hEE);
    n_tests++;
    if (o_ovfl !== 1'b1) begin n_fail++; $display("FAIL flush_pre_ovfl: got %b expected 1", o_ovfl); end
    i_flush = 1; i_wr = 1; i_data = 8'h99; tick();
    n_tests++;
    if (o_fill !== 5'd0 || o_empty_n !== 1'b0 || o_ovfl !== 1'b1 || o_unfl !== 1'b0) begin
      n_fail++; $display("FAIL flush: fill %0d empty_n %b ovfl %b unfl %b expected 0/0/1/0", o_fill, o_empty_n, o_ovfl, o_unfl);
    end
    wr(8'h11);
    n_tests++;
    if (o_data !== 8'h11 || o_fill !== 5'd1) begin
      n_fail++; $display("FAIL post_flush: data %h fill %0d expected 11/1", o_data, o_fill);
    end
    rd();
    i_clr_err = 1; tick();
    n_tests++;
    if (o_ovfl !== 1'b0) begin n_fail++; $display("FAIL clr_err: ovfl %b expected 0", o_ovfl); end
    i_clr_err = 1; i_rd = 1; tick();
    n_tests++;
    if (o_unfl !== 1'b1 || t_unfl !== 1'b1) begin
      n_fail++; $display("FAIL clr_vs_unfl: rx %b tx %b expected 1", o_unfl, t_unfl);
    end
    i_clr_err = 1; tick();
  endtask

  task automatic test_reset_mid();
    i_thresh = 4;
    for (int i = 0; i < 9; i++) wr(8'(8'h50 + i));
    i_wr = 1; i_data = 8'hEE; tick();
    i_rd = 1; i_rst = 1; tick();
    n_tests++;
    if ({o_fill, o_empty_n, o_full, o_half_full, o_ovfl, o_unfl, o_thresh} !== 11'd0 || t_thresh !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid: fill %0d e %b f %b h %b ov %b un %b th %b tth %b",
                         o_fill, o_empty_n, o_full, o_half_full, o_ovfl, o_unfl, o_thresh, t_thresh);
    end
    wr(8'h33);
    n_tests++;
    if (o_data !== 8'h33 || o_fill !== 5'd1 || o_status !== 16'h4005) begin
      n_fail++; $display("FAIL reset_mid_write: data %h fill %0d status %h expected 33/1/4005", o_data, o_fill, o_status);
    end
    rd();
    n_tests++;
    if (o_empty_n !== 1'b0) begin n_fail++; $display("FAIL reset_mid_drain: empty_n %b expected 0", o_empty_n); end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill_wrap();
    test_fwft();
    test_simul();
    test_thresh();
    test_flush_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
